// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [WIDTH-1:0] res, res_d;
    logic             bf, bf_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             busy_d, done_d, borrow_d;
    logic [WIDTH-1:0] diff_d;

    // Full-subtractor cell on the current LSBs
    logic a0, b0, d_c, bo_c;
    assign a0   = sa[0];
    assign b0   = sb[0];
    assign d_c  = a0 ^ b0 ^ bf;
    assign bo_c = (~a0 & b0) | (~(a0 ^ b0) & bf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            state  <= state_d;
            sa     <= sa_d;
            sb     <= sb_d;
            res    <= res_d;
            bf     <= bf_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            done   <= done_d;
            diff   <= diff_d;
            borrow <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state;
        sa_d     = sa;
        sb_d     = sb;
        res_d    = res;
        bf_d     = bf;
        cnt_d    = cnt;
        busy_d   = busy;
        done_d   = 1'b0;
        diff_d   = diff;
        borrow_d = borrow;

        case (state)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = {d_c, res[WIDTH-1:1]};
                sa_d  = {1'b0, sa[WIDTH-1:1]};
                sb_d  = {1'b0, sb[WIDTH-1:1]};
                bf_d  = bo_c;
                cnt_d = cnt + CW'(1);
                // Last bit: publish result; diff/borrow stay frozen otherwise
                if (cnt == CW'(WIDTH - 1)) begin
                    diff_d   = res_d;
                    borrow_d = bo_c;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected
// {borrow, diff} values popped when done pulses.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    int     total = 0;
    int     passed = 0;
    logic [W:0] sb_q[$];
    logic [W:0] last_res = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    always #5 clk = ~clk;

    // Launch one op, wait for done, compare latency, busy span, hold and result
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
        int cyc, busy_cyc;
        bit seen, hold_ok;
        logic [W:0] exp;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        sb_q.push_back({1'b0, av} - {1'b0, bv});
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; busy_cyc = 0; seen = 0; hold_ok = 1;
        while (!seen && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) seen = 1;
            else if ({borrow, diff} !== last_res) hold_ok = 0;
        end
        total++;
        if (!seen) $display("FAIL %s done_seen: got 0 want 1 within %0d cycles", name, 4 * W);
        else passed++;
        total++;
        if (cyc != W + 1) $display("FAIL %s latency: got %0d want %0d", name, cyc, W + 1);
        else passed++;
        total++;
        if (busy_cyc != W) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, W);
        else passed++;
        total++;
        if (!hold_ok) $display("FAIL %s outputs_held_during_shift: got changed want stable %h", name, last_res);
        else passed++;
        exp = sb_q.pop_front();
        total++;
        if (diff !== exp[W-1:0]) $display("FAIL %s diff: got %h want %h", name, diff, exp[W-1:0]);
        else passed++;
        total++;
        if (borrow !== exp[W]) $display("FAIL %s borrow: got %b want %b", name, borrow, exp[W]);
        else passed++;
        last_res = exp;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL %s done_one_cycle: got %b want 0", name, done);
        else passed++;
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        total++;
        if (bad) $display("FAIL %s quiet: got done/busy activity want none", name);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        total++;
        if ({busy, done, borrow, diff} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
    endtask

    task automatic test_directed();
        do_op(8'd100, 8'd37, "a100_b37");
        do_op(8'd5, 8'd9, "a5_b9");
        do_op(8'hA5, 8'hA5, "equal");
        do_op(8'h00, 8'hFF, "a0_bff");
        do_op(8'h80, 8'h01, "borrow_chain");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "random");
    endtask

    // start pulsed mid-SHIFT with new operands must be ignored
    task automatic test_ignore_start();
        int cyc = 0;
        bit seen = 0;
        logic [W:0] exp;
        @(negedge clk);
        a = 8'd200; b = 8'd50; start = 1'b1;
        sb_q.push_back({1'b0, 8'd200} - {1'b0, 8'd50});
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
            if (cyc == 4) begin start = 1'b0; a = 8'hFF; b = 8'h00; end
            if (done === 1'b1) seen = 1;
        end
        exp = sb_q.pop_front();
        total++;
        if (!seen || diff !== exp[W-1:0] || borrow !== exp[W])
            $display("FAIL ignore_start_result: got seen=%b diff=%h borrow=%b want diff=%h borrow=%b",
                     seen, diff, borrow, exp[W-1:0], exp[W]);
        else passed++;
        last_res = exp;
        expect_quiet(3 * W, "ignore_start_no_second_done");
        do_op(8'h10, 8'h01, "after_ignore");
    endtask

    // Asynchronous reset between edges aborts the op and clears outputs at once
    task automatic test_reset_mid_shift();
        do_op(8'd5, 8'd9, "pre_reset");
        @(negedge clk);
        a = 8'd77; b = 8'd11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, borrow, diff} !== '0)
            $display("FAIL async_reset_clear: got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        expect_quiet(2 * W, "reset_abort_no_done");
        do_op(8'd3, 8'd2, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_shift();
        total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
